// File: rtl/arm_scale_pkg.sv
// arm_scale_pkg: shared FSM state type and default parameters
// for arm_scale_measure and its counter sub-module.
package arm_scale_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/arm_scale_edge_cnt.sv
// arm_scale_edge_cnt: saturating up-counter with sticky overflow.
// Ports: clr/ovf_clr/load1/inc controls, cnt, nxt (cnt+1 sat), ovf.
import arm_scale_pkg::*;

module arm_scale_edge_cnt #(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         ovf_clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         ovf
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic at_max;

  assign at_max = (cnt == MAX);
  assign nxt    = at_max ? MAX : cnt + ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (ovf_clr)
        ovf <= 1'b0;
      else if (inc && at_max)
        ovf <= 1'b1;
      if (clr)
        cnt <= '0;
      else if (load1)
        cnt <= ONE;
      else if (inc)
        cnt <= nxt;
    end
  end

endmodule

// File: rtl/arm_scale_measure.sv
// arm_scale_measure: measures init/high/low cycle counts of cin, lock/mismatch.
// Ports: clk, reset_n, start, cin -> init/high/low_cnt, meas_valid, locked,
// mismatch, ovf, stuck. Optional timeout: ARM_SCALE_MEASURE_TIMEOUT_EN.
import arm_scale_pkg::*;

module arm_scale_measure #(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cin,
  output logic [CNT_W-1:0] init_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             ovf,
  output logic             stuck
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);
  localparam logic [MW-1:0] ONE_M  = MW'(1);

  state_t           state;
  logic             cin_q;
  logic             rise;
  logic             fall;
  logic             active;
  logic             tmo_fire;
  logic             cnt_clr;
  logic             cnt_load1;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt;
  logic [CNT_W-1:0] high_cap;
  logic [MW-1:0]    match;
  logic [MW-1:0]    match_inc;
  logic             same;

  assign rise   = cin & ~cin_q;
  assign fall   = ~cin & cin_q;
  assign active = (state != IDLE);

  // The rise that ends WAIT_FIRST is itself the first high cycle,
  // so the counter restarts at 1 on every captured edge.
  assign cnt_load1 = ((state == WAIT_FIRST) && rise)
                   | ((state == MEAS_HIGH) && fall)
                   | ((state == MEAS_LOW) && rise);
  assign cnt_clr   = start | tmo_fire;
  // init_cnt takes nxt on the rise, so that cycle still counts
  // toward saturation.
  assign cnt_inc   = active & ~cnt_clr
                   & ((state == WAIT_FIRST) | ~cnt_load1);

  assign same = (high_cap == high_cnt) && (cnt == low_cnt);
  assign match_inc = (match == LOCK_M) ? LOCK_M : match + ONE_M;

  arm_scale_edge_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .ovf_clr (start),
    .load1   (cnt_load1),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .nxt     (nxt),
    .ovf     (ovf)
  );

`ifdef ARM_SCALE_MEASURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_fire = active & ~start & ~rise & ~fall
                  & (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      stuck   <= 1'b0;
    end else begin
      if (start || rise || fall || !active || tmo_fire)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);
      if (start)
        stuck <= 1'b0;
      else if (tmo_fire)
        stuck <= 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign stuck    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cin_q      <= 1'b0;
      init_cnt   <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      high_cap   <= '0;
      match      <= '0;
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      cin_q      <= cin;
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      if (start) begin
        state    <= WAIT_FIRST;
        init_cnt <= '0;
        high_cnt <= '0;
        low_cnt  <= '0;
        high_cap <= '0;
        match    <= '0;
        locked   <= 1'b0;
      end else if (tmo_fire) begin
        // Forget the reference period; the next one starts afresh.
        state  <= WAIT_FIRST;
        match  <= '0;
        locked <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          WAIT_FIRST: begin
            if (rise) begin
              init_cnt <= nxt;
              state    <= MEAS_HIGH;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              high_cap <= cnt;
              state    <= MEAS_LOW;
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              high_cnt   <= high_cap;
              low_cnt    <= cnt;
              meas_valid <= 1'b1;
              state      <= MEAS_HIGH;
              if (match == '0) begin
                match  <= ONE_M;
                locked <= (ONE_M == LOCK_M);
              end else if (same) begin
                match  <= match_inc;
                locked <= (match_inc == LOCK_M);
              end else begin
                match    <= ONE_M;
                locked   <= 1'b0;
                mismatch <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arm_scale_measure.sv
// tb_arm_scale_measure: directed vector table plus hand sequences
// for arm_scale_measure (main instance and a 4-bit counter instance).
module tb_arm_scale_measure;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        cin;
  logic [15:0] init_cnt, high_cnt, low_cnt;
  logic        meas_valid, locked, mismatch, ovf, stuck;
  logic [3:0]  init4, high4, low4;
  logic        mv4, locked4, mm4, ovf4, stuck4;

  int n_tests = 0;
  int n_fail  = 0;
  int spur    = 0;
  int exp_stk;
  int exp_lck;

  typedef struct {
    int h;
    int l;
    int ehi;
    int elo;
    int elock;
    int emm;
  } vec_t;

  vec_t v[12];

  always #5 clk = ~clk;

  arm_scale_measure #(
    .CNT_W    (16),
    .LOCK_CNT (4),
    .TIMEOUT  (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .cin        (cin),
    .init_cnt   (init_cnt),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .meas_valid (meas_valid),
    .locked     (locked),
    .mismatch   (mismatch),
    .ovf        (ovf),
    .stuck      (stuck)
  );

  arm_scale_measure #(
    .CNT_W    (4),
    .LOCK_CNT (4),
    .TIMEOUT  (1024)
  ) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .cin        (cin),
    .init_cnt   (init4),
    .high_cnt   (high4),
    .low_cnt    (low4),
    .meas_valid (mv4),
    .locked     (locked4),
    .mismatch   (mm4),
    .ovf        (ovf4),
    .stuck      (stuck4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      if (meas_valid) spur++;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic period(input int h, input int l);
    tick_n(h - 1);
    cin = 1'b0;
    tick_n(l);
    cin = 1'b1;
    tick();
  endtask

  initial begin
    start   = 1'b0;
    cin     = 1'b0;
    reset_n = 1'b0;

    v[0]  = '{3, 2, 3, 2, 0, 0};
    v[1]  = '{3, 2, 3, 2, 0, 0};
    v[2]  = '{3, 2, 3, 2, 0, 0};
    v[3]  = '{3, 2, 3, 2, 1, 0};
    v[4]  = '{3, 2, 3, 2, 1, 0};
    v[5]  = '{4, 2, 4, 2, 0, 1};
    v[6]  = '{3, 2, 3, 2, 0, 1};
    v[7]  = '{3, 2, 3, 2, 0, 0};
    v[8]  = '{3, 2, 3, 2, 0, 0};
    v[9]  = '{3, 2, 3, 2, 1, 0};
    v[10] = '{2, 5, 2, 5, 0, 1};
    v[11] = '{2, 5, 2, 5, 0, 0};

    tick();
    tick();
    chk("rst_init", init_cnt, 0);
    chk("rst_high", high_cnt, 0);
    chk("rst_low", low_cnt, 0);
    chk("rst_mv", meas_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_mm", mismatch, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_ovf4", ovf4, 0);

    reset_n = 1'b1;
    tick();
    cin = 1'b1;
    tick();
    cin = 1'b0;
    tick();
    chk("idle_init", init_cnt, 0);

    // first rise 3 cycles after start
    do_start();
    tick();
    tick();
    cin = 1'b1;
    tick();
    chk("init3", init_cnt, 3);
    chk("init3_mv", meas_valid, 0);

    for (int i = 0; i < 12; i++) begin
      spur = 0;
      period(v[i].h, v[i].l);
      chk($sformatf("v%0d_mv", i), meas_valid, 1);
      chk($sformatf("v%0d_hi", i), high_cnt, v[i].ehi);
      chk($sformatf("v%0d_lo", i), low_cnt, v[i].elo);
      chk($sformatf("v%0d_lock", i), locked, v[i].elock);
      chk($sformatf("v%0d_mm", i), mismatch, v[i].emm);
      chk($sformatf("v%0d_spur", i), spur, 0);
    end

    // start coincident with a rise: rise ignored, outputs cleared
    cin = 1'b0;
    tick();
    start = 1'b1;
    cin   = 1'b1;
    tick();
    start = 1'b0;
    chk("st_clr_hi", high_cnt, 0);
    chk("st_clr_lo", low_cnt, 0);
    chk("st_clr_init", init_cnt, 0);
    tick();
    chk("st_rise_ign", init_cnt, 0);
    cin = 1'b0;
    tick();
    tick();
    cin = 1'b1;
    tick();
    chk("init4", init_cnt, 4);

    // 4-bit instance: 20 high cycles saturate at 15
    tick();
    tick_n(9);
    chk("ovf4_pre", ovf4, 0);
    tick_n(9);
    cin = 1'b0;
    tick();
    tick();
    cin = 1'b1;
    tick();
    chk("sat_mv4", mv4, 1);
    chk("sat_hi4", high4, 15);
    chk("sat_lo4", low4, 2);
    chk("sat_ovf4", ovf4, 1);
    period(3, 2);
    chk("sat_hi4_b", high4, 3);
    chk("ovf4_sticky", ovf4, 1);
    cin = 1'b0;
    tick();
    do_start();
    chk("ovf4_clr", ovf4, 0);

    // relock then hold cin constant
    tick();
    cin = 1'b1;
    tick();
    chk("init2", init_cnt, 2);
    for (int i = 0; i < 4; i++) period(3, 2);
    chk("relock", locked, 1);
    chk("relock_hi", high_cnt, 3);
    tick_n(15);
    chk("tmo_pre_stuck", stuck, 0);
    chk("tmo_pre_lock", locked, 1);
`ifdef ARM_SCALE_MEASURE_TIMEOUT_EN
    exp_stk = 1;
    exp_lck = 0;
`else
    exp_stk = 0;
    exp_lck = 1;
`endif
    tick();
    chk("tmo_stuck", stuck, exp_stk);
    chk("tmo_lock", locked, exp_lck);
    tick_n(10);
    chk("tmo_stuck_hold", stuck, exp_stk);
    chk("tmo_init_keep", init_cnt, 2);

    // asynchronous reset in the low phase
    cin = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("ar_init", init_cnt, 0);
    chk("ar_high", high_cnt, 0);
    chk("ar_low", low_cnt, 0);
    chk("ar_lock", locked, 0);
    chk("ar_mv", meas_valid, 0);
    chk("ar_mm", mismatch, 0);
    chk("ar_stuck", stuck, 0);
    tick();
    reset_n = 1'b1;
    spur = 0;
    for (int i = 0; i < 3; i++) begin
      cin = 1'b1;
      tick_n(3);
      cin = 1'b0;
      tick_n(2);
    end
    chk("ar_no_mv", spur, 0);
    chk("ar_high_hold", high_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
